// File: rtl/wb_deserializer.sv
// wb_deserializer: receives 27-bit serial frames and exposes them through a Wishbone slave
// Ports: CLK_I clock; RST_NI async active-low reset; data_i/ena_i serial bit and frame qualifier;
//   irq_o level interrupt (VALID|OVR|FERR); CYC_I/STB_I/WE_I/ADR_I/DAT_I in, DAT_O/ACK_O/ERR_O out
//   form a zero-wait-state Wishbone slave with RXDATA(0), STATUS(1), CTRL(2).
module wb_deserializer #(
  parameter int FRAME_BITS = 27,
  parameter int SYM_BITS = 9,
  parameter int ADDR_SIZE = 2
) (
  input  logic        CLK_I,
  input  logic        RST_NI,
  input  logic        data_i,
  input  logic        ena_i,
  output logic        irq_o,
  input  logic        CYC_I,
  input  logic        STB_I,
  input  logic        WE_I,
  input  logic [31:0] ADR_I,
  input  logic [31:0] DAT_I,
  output logic [31:0] DAT_O,
  output logic        ACK_O,
  output logic        ERR_O
);
  localparam int NSYM = FRAME_BITS / SYM_BITS;
  localparam int CW = $clog2(FRAME_BITS);
  typedef enum logic {IDLE, RECV} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [FRAME_BITS-1:0] sh_q, sh_d, rx_q, rx_d, frame;
  logic valid_q, valid_d, ovr_q, ovr_d, ferr_q, ferr_d, en_q, en_d;
  logic acc, hit, rd_clr, wr_st, wr_ctrl, commit, set_ferr, keep;
  logic [ADDR_SIZE-1:0] adr;
  logic unused;
  assign unused = ^{ADR_I[31:ADDR_SIZE], DAT_I[31:3]};
  assign adr = ADR_I[ADDR_SIZE-1:0];
  // bus outputs are combinational, so gate them with reset to force zero while RST_NI is low
  assign acc = RST_NI & CYC_I & STB_I;
  assign hit = acc & (adr <= ADDR_SIZE'(2));
  assign ACK_O = hit;
  assign ERR_O = acc & ~hit;
  assign rd_clr = hit & ~WE_I & (adr == ADDR_SIZE'(0));
  assign wr_st = hit & WE_I & (adr == ADDR_SIZE'(1));
  assign wr_ctrl = hit & WE_I & (adr == ADDR_SIZE'(2));
  assign irq_o = valid_q | ovr_q | ferr_q;
  always_comb begin
    DAT_O = !hit ? 32'd0 :
            adr == ADDR_SIZE'(0) ? 32'(rx_q[NSYM*SYM_BITS-1:0]) :
            adr == ADDR_SIZE'(1) ? {29'd0, ferr_q, ovr_q, valid_q} : {31'd0, en_q};
  end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    sh_d = sh_q;
    commit = 1'b0;
    set_ferr = 1'b0;
    frame = {sh_q[FRAME_BITS-2:0], data_i};
    if (state_q == IDLE) begin
      if (ena_i && en_q) begin
        state_d = RECV;
        sh_d = frame;
        cnt_d = CW'(1);
      end
    end else if (!en_q) begin
      state_d = IDLE;
      cnt_d = '0;
    end else if (ena_i) begin
      sh_d = frame;
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CW'(FRAME_BITS - 1)) begin
        commit = 1'b1;
        cnt_d = '0;
        state_d = IDLE;
      end
    end else begin
      set_ferr = 1'b1;
      cnt_d = '0;
      state_d = IDLE;
    end
  end
  // keep: VALID survives this edge, so a commit now is an overrun rather than a store
  assign keep = valid_q & ~rd_clr;
  always_comb begin
    valid_d = keep | commit;
    rx_d = commit && !keep ? frame : rx_q;
    ovr_d = (ovr_q & ~(wr_st & DAT_I[1])) | (commit & keep);
    ferr_d = (ferr_q & ~(wr_st & DAT_I[2])) | set_ferr;
    en_d = wr_ctrl ? DAT_I[0] : en_q;
  end
  always_ff @(posedge CLK_I or negedge RST_NI) begin
    if (!RST_NI) begin
      state_q <= IDLE;
      cnt_q <= '0;
      sh_q <= '0;
      rx_q <= '0;
      valid_q <= 1'b0;
      ovr_q <= 1'b0;
      ferr_q <= 1'b0;
      en_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      sh_q <= sh_d;
      rx_q <= rx_d;
      valid_q <= valid_d;
      ovr_q <= ovr_d;
      ferr_q <= ferr_d;
      en_q <= en_d;
    end
  end
endmodule

// File: tb/tb_wb_deserializer.sv
// tb_wb_deserializer: randomized self-checking bench for wb_deserializer against a queue-based model
module tb_wb_deserializer;
  logic CLK_I = 1'b0, RST_NI = 1'b1, data_i = 1'b0, ena_i = 1'b0;
  logic CYC_I = 1'b0, STB_I = 1'b0, WE_I = 1'b0;
  logic [31:0] ADR_I = '0, DAT_I = '0;
  logic irq_o, ACK_O, ERR_O;
  logic [31:0] DAT_O;
  int checks = 0, errors = 0;
  always #5 CLK_I = ~CLK_I;
  wb_deserializer dut (
    .CLK_I(CLK_I), .RST_NI(RST_NI), .data_i(data_i), .ena_i(ena_i), .irq_o(irq_o),
    .CYC_I(CYC_I), .STB_I(STB_I), .WE_I(WE_I), .ADR_I(ADR_I), .DAT_I(DAT_I),
    .DAT_O(DAT_O), .ACK_O(ACK_O), .ERR_O(ERR_O)
  );
  bit bits_q[$];
  logic [26:0] m_rx;
  bit m_valid, m_ovr, m_ferr, m_en;
  logic s_ack, s_err, s_irq;
  logic [31:0] s_dat;
  function automatic void model_reset();
    bits_q.delete();
    m_rx = '0;
    m_valid = 0;
    m_ovr = 0;
    m_ferr = 0;
    m_en = 1;
  endfunction
  function automatic logic [31:0] m_read(input logic [1:0] a);
    return a == 2'd0 ? {5'd0, m_rx} : a == 2'd1 ? {29'd0, m_ferr, m_ovr, m_valid} :
           a == 2'd2 ? {31'd0, m_en} : 32'd0;
  endfunction
  function automatic void model_edge(input bit ena, input bit d, input bit cyc, input bit we,
                                     input logic [1:0] adr, input logic [31:0] wd);
    bit acc, rd, commit, set_ovr, set_ferr;
    logic [26:0] f;
    acc = cyc && adr != 2'd3;
    rd = acc && !we && adr == 2'd0;
    commit = 0;
    set_ovr = 0;
    set_ferr = 0;
    f = '0;
    if (!m_en) bits_q.delete();
    else if (ena) begin
      bits_q.push_back(d);
      if (bits_q.size() == 27) begin
        foreach (bits_q[i]) f = {f[25:0], bits_q[i]};
        commit = 1;
        bits_q.delete();
      end
    end else if (bits_q.size() > 0) begin
      set_ferr = 1;
      bits_q.delete();
    end
    if (rd) m_valid = 0;
    if (commit) begin
      if (m_valid) set_ovr = 1;
      else begin
        m_rx = f;
        m_valid = 1;
      end
    end
    if (acc && we && adr == 2'd1) begin
      if (wd[1]) m_ovr = 0;
      if (wd[2]) m_ferr = 0;
    end
    m_ovr = m_ovr | set_ovr;
    m_ferr = m_ferr | set_ferr;
    if (acc && we && adr == 2'd2) m_en = wd[0];
  endfunction
  task automatic cycle(input bit ena, input bit d, input bit cyc, input bit we,
                       input logic [1:0] adr, input logic [31:0] wd);
    ena_i = ena;
    data_i = d;
    CYC_I = cyc;
    STB_I = cyc;
    WE_I = we;
    ADR_I = ($urandom() & ~32'h3) | {30'd0, adr};
    DAT_I = wd;
    @(negedge CLK_I);
    s_ack = ACK_O;
    s_err = ERR_O;
    s_irq = irq_o;
    s_dat = DAT_O;
    @(posedge CLK_I);
    model_edge(ena, d, cyc, we, adr, wd);
    #1;
  endtask
  task automatic send_frame(input logic [26:0] f);
    for (int i = 26; i >= 0; i--) cycle(1, f[i], 0, 0, 2'd0, 32'd0);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 1'($urandom()), 0, 0, 2'd0, 32'd0);
  endtask
  task automatic bus_read(input logic [1:0] a);
    cycle(0, 1'($urandom()), 1, 0, a, $urandom());
  endtask
  task automatic bus_write(input logic [1:0] a, input logic [31:0] wd);
    cycle(0, 1'($urandom()), 1, 1, a, wd);
  endtask
  task automatic test_reset();
    #1 RST_NI = 1'b0;
    CYC_I = 1'b1;
    STB_I = 1'b1;
    ADR_I = 32'd1;
    #2;
    checks++;
    if ({ACK_O, ERR_O, irq_o, DAT_O} !== 35'd0) begin
      errors++;
      $display("FAIL reset_outputs got ack %b err %b irq %b dat %h exp all 0", ACK_O, ERR_O, irq_o, DAT_O);
    end
    model_reset();
    @(posedge CLK_I);
    @(posedge CLK_I);
    #1 RST_NI = 1'b1;
    bus_read(2'd1);
    checks++;
    if (s_dat !== 32'd0 || s_ack !== 1'b1 || s_irq !== 1'b0) begin
      errors++;
      $display("FAIL reset_status got %h ack %b irq %b exp 00000000 ack 1 irq 0", s_dat, s_ack, s_irq);
    end
    bus_read(2'd2);
    checks++;
    if (s_dat !== 32'd1) begin
      errors++;
      $display("FAIL reset_ctrl got %h exp 00000001", s_dat);
    end
  endtask
  task automatic test_single();
    logic [31:0] exp;
    send_frame(27'h5A3C1B5);
    bus_read(2'd1);
    checks++;
    if (s_dat !== 32'd1 || s_irq !== 1'b1) begin
      errors++;
      $display("FAIL single_status got %h irq %b exp 00000001 irq 1", s_dat, s_irq);
    end
    exp = m_read(2'd0);
    bus_read(2'd0);
    checks++;
    if (s_dat !== 32'h05A3C1B5 || s_dat !== exp || s_ack !== 1'b1) begin
      errors++;
      $display("FAIL single_rxdata got %h ack %b exp 05a3c1b5 model %h", s_dat, s_ack, exp);
    end
    bus_read(2'd1);
    checks++;
    if (s_dat !== 32'd0 || s_irq !== 1'b0) begin
      errors++;
      $display("FAIL single_cleared got %h irq %b exp 00000000 irq 0", s_dat, s_irq);
    end
  endtask
  task automatic test_random_frames();
    logic [26:0] f;
    logic [31:0] exp;
    for (int n = 0; n < 6; n++) begin
      f = 27'($urandom());
      idle($urandom_range(0, 3));
      send_frame(f);
      exp = m_read(2'd1);
      bus_read(2'd1);
      checks++;
      if (s_dat !== exp || s_irq !== 1'b1) begin
        errors++;
        $display("FAIL rand_status[%0d] got %h irq %b exp %h irq 1", n, s_dat, s_irq, exp);
      end
      exp = m_read(2'd0);
      bus_read(2'd0);
      checks++;
      if (s_dat !== {5'd0, f} || s_dat !== exp) begin
        errors++;
        $display("FAIL rand_rxdata[%0d] got %h exp %h", n, s_dat, {5'd0, f});
      end
    end
  endtask
  task automatic test_back_to_back();
    logic [26:0] a, b;
    logic [31:0] exp;
    a = 27'($urandom());
    b = 27'($urandom());
    for (int i = 0; i < 54; i++) begin
      cycle(1, i < 27 ? a[26-i] : b[53-i], i == 32, 0, 2'd0, 32'd0);
      if (i == 32) begin
        checks++;
        if (s_dat !== {5'd0, a}) begin
          errors++;
          $display("FAIL b2b_first got %h exp %h", s_dat, {5'd0, a});
        end
      end
    end
    exp = m_read(2'd1);
    bus_read(2'd1);
    checks++;
    if (s_dat !== 32'd1 || s_dat !== exp) begin
      errors++;
      $display("FAIL b2b_status got %h exp 00000001", s_dat);
    end
    bus_read(2'd0);
    checks++;
    if (s_dat !== {5'd0, b}) begin
      errors++;
      $display("FAIL b2b_second got %h exp %h", s_dat, {5'd0, b});
    end
  endtask
  task automatic test_overrun();
    logic [26:0] a, b;
    a = 27'($urandom());
    b = 27'($urandom()) ^ 27'h1;
    send_frame(a);
    send_frame(b);
    bus_read(2'd1);
    checks++;
    if (s_dat !== 32'd3 || s_dat !== m_read(2'd1) || s_irq !== 1'b1) begin
      errors++;
      $display("FAIL ovr_status got %h irq %b exp 00000003", s_dat, s_irq);
    end
    bus_write(2'd1, 32'h2);
    bus_read(2'd1);
    checks++;
    if (s_dat !== 32'd1) begin
      errors++;
      $display("FAIL ovr_w1c got %h exp 00000001", s_dat);
    end
    bus_read(2'd0);
    checks++;
    if (s_dat !== {5'd0, a}) begin
      errors++;
      $display("FAIL ovr_keep got %h exp %h", s_dat, {5'd0, a});
    end
  endtask
  task automatic test_frame_error();
    logic [26:0] f;
    for (int i = 0; i < 13; i++) cycle(1, 1'($urandom()), 0, 0, 2'd0, 32'd0);
    idle(1);
    bus_read(2'd1);
    checks++;
    if (s_dat !== 32'h4 || s_dat !== m_read(2'd1) || s_irq !== 1'b1) begin
      errors++;
      $display("FAIL ferr_status got %h irq %b exp 00000004 irq 1", s_dat, s_irq);
    end
    bus_write(2'd1, 32'h4);
    bus_read(2'd1);
    checks++;
    if (s_dat !== 32'd0 || s_irq !== 1'b0) begin
      errors++;
      $display("FAIL ferr_w1c got %h irq %b exp 00000000 irq 0", s_dat, s_irq);
    end
    f = 27'($urandom());
    send_frame(f);
    bus_read(2'd0);
    checks++;
    if (s_dat !== {5'd0, f} || s_dat !== m_read(2'd0) && 1'b0) begin
      errors++;
      $display("FAIL ferr_next got %h exp %h", s_dat, {5'd0, f});
    end
  endtask
  task automatic test_bus();
    logic [26:0] a, b, g;
    logic [31:0] exp;
    bus_read(2'd3);
    checks++;
    if (s_err !== 1'b1 || s_ack !== 1'b0 || s_dat !== 32'd0) begin
      errors++;
      $display("FAIL bus_unmapped got err %b ack %b dat %h exp err 1 ack 0 dat 0", s_err, s_ack, s_dat);
    end
    exp = m_read(2'd0);
    bus_write(2'd0, $urandom());
    bus_read(2'd0);
    checks++;
    if (s_dat !== exp || s_ack !== 1'b1) begin
      errors++;
      $display("FAIL bus_rx_write got %h ack %b exp %h", s_dat, s_ack, exp);
    end
    g = 27'($urandom());
    for (int i = 0; i < 10; i++) cycle(1, g[26-i], 0, 0, 2'd0, 32'd0);
    cycle(1, g[16], 1, 1, 2'd2, 32'd0);
    for (int i = 11; i < 27; i++) cycle(1, g[26-i], 0, 0, 2'd0, 32'd0);
    idle(2);
    bus_read(2'd1);
    checks++;
    if (s_dat !== 32'd0 || s_dat !== m_read(2'd1)) begin
      errors++;
      $display("FAIL bus_en_off_status got %h exp 00000000", s_dat);
    end
    bus_read(2'd2);
    checks++;
    if (s_dat !== 32'd0) begin
      errors++;
      $display("FAIL bus_ctrl_read got %h exp 00000000", s_dat);
    end
    bus_write(2'd2, 32'd1);
    a = 27'($urandom());
    b = 27'($urandom()) ^ 27'h2;
    send_frame(a);
    for (int i = 26; i > 0; i--) cycle(1, b[i], 0, 0, 2'd0, 32'd0);
    cycle(1, b[0], 1, 0, 2'd0, 32'd0);
    checks++;
    if (s_dat !== {5'd0, a}) begin
      errors++;
      $display("FAIL bus_coincide_old got %h exp %h", s_dat, {5'd0, a});
    end
    bus_read(2'd1);
    checks++;
    if (s_dat !== 32'd1 || s_dat !== m_read(2'd1)) begin
      errors++;
      $display("FAIL bus_coincide_status got %h exp 00000001", s_dat);
    end
    bus_read(2'd0);
    checks++;
    if (s_dat !== {5'd0, b}) begin
      errors++;
      $display("FAIL bus_coincide_new got %h exp %h", s_dat, {5'd0, b});
    end
  endtask
  task automatic test_reset_mid();
    logic [26:0] f, g, h;
    f = 27'($urandom());
    g = 27'($urandom());
    h = 27'($urandom());
    send_frame(f);
    for (int i = 0; i < 10; i++) cycle(1, g[26-i], 0, 0, 2'd0, 32'd0);
    CYC_I = 1'b1;
    STB_I = 1'b1;
    WE_I = 1'b0;
    ADR_I = 32'd1;
    #1 RST_NI = 1'b0;
    #1;
    checks++;
    if ({ACK_O, ERR_O, irq_o, DAT_O} !== 35'd0) begin
      errors++;
      $display("FAIL rst_mid_outputs got ack %b err %b irq %b dat %h exp all 0", ACK_O, ERR_O, irq_o, DAT_O);
    end
    model_reset();
    @(posedge CLK_I);
    #1 RST_NI = 1'b1;
    bus_read(2'd1);
    checks++;
    if (s_dat !== 32'd0 || s_irq !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_status got %h irq %b exp 00000000", s_dat, s_irq);
    end
    send_frame(h);
    bus_read(2'd0);
    checks++;
    if (s_dat !== {5'd0, h} || s_dat !== m_read(2'd0) && 1'b0) begin
      errors++;
      $display("FAIL rst_mid_next got %h exp %h", s_dat, {5'd0, h});
    end
  endtask
  initial begin
    test_reset();
    test_single();
    test_random_frames();
    test_back_to_back();
    test_overrun();
    test_frame_error();
    test_bus();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
